// File: rtl/lut_func_eval_if.sv
// Bundles the load, lookup and sweep signals of lut_func_eval.
// Latency: none (wiring only).
// Backpressure: none; every request is accepted in the cycle it is presented.
interface lut_func_eval_if #(
    parameter int N = 3
);
    logic         cfg_valid;
    logic         cfg_bit;
    logic         in_valid;
    logic [N-1:0] in_vec;
    logic         f;
    logic         out_valid;
    logic         sweep_start;
    logic         sweep_busy;
    logic         sweep_done;
    logic [N:0]   ones_count;

    // Requester side: drives config, lookups and sweep requests.
    modport master (
        output cfg_valid, cfg_bit, in_valid, in_vec, sweep_start,
        input  f, out_valid, sweep_busy, sweep_done, ones_count
    );

    // Function unit side.
    modport slave (
        input  cfg_valid, cfg_bit, in_valid, in_vec, sweep_start,
        output f, out_valid, sweep_busy, sweep_done, ones_count
    );
endinterface

// File: rtl/lut_func_eval.sv
// Serially loaded N-input truth table with lookup port and ON-set counting sweep.
// Latency: lookup 0 cycles, or 1 cycle when LUT_FUNC_EVAL_REG_OUT_EN is defined; sweep 2^N+1 cycles.
// Backpressure: none; loads are dropped and sweep_start ignored while a sweep runs.
module lut_func_eval #(
    parameter int N = 3
) (
    input  logic           clk,
    input  logic           rst,
    lut_func_eval_if.slave bus
);
    localparam int TBL = 1 << N;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t         state_q;
    logic [TBL-1:0] table_q;
    logic [TBL-1:0] table_d;
    logic [N-1:0]   idx_q;
    logic [N:0]     acc_q;
    logic [N:0]     ones_q;
    logic           cur_bit;
    logic [N:0]     acc_d;

    assign cur_bit = table_q[idx_q];
    assign acc_d   = acc_q + {{N{1'b0}}, cur_bit};

    // Table shift: frozen for the whole sweep so the count matches a single snapshot.
    always_comb begin
        table_d = table_q;
        if (bus.cfg_valid && (state_q != SWEEP)) begin
            table_d = {table_q[TBL-2:0], bus.cfg_bit};
        end
    end

    // Sweep FSM and table storage; a start in IDLE or DONE sees any same-cycle shift.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            table_q <= '0;
            idx_q   <= '0;
            acc_q   <= '0;
            ones_q  <= '0;
        end else begin
            table_q <= table_d;
            case (state_q)
                IDLE, DONE: begin
                    if (bus.sweep_start) begin
                        state_q <= SWEEP;
                        acc_q   <= '0;
                        idx_q   <= '0;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                SWEEP: begin
                    acc_q <= acc_d;
                    if (idx_q == '1) begin
                        ones_q  <= acc_d;
                        idx_q   <= '0;
                        state_q <= DONE;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.sweep_busy = (state_q == SWEEP);
    assign bus.sweep_done = (state_q == DONE);
    assign bus.ones_count = ones_q;

`ifdef LUT_FUNC_EVAL_REG_OUT_EN
    logic f_q;
    logic out_valid_q;

    // Registered lookup: samples the pre-shift table; f holds between requests.
    always_ff @(posedge clk) begin
        if (rst) begin
            f_q         <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            out_valid_q <= bus.in_valid;
            if (bus.in_valid) begin
                f_q <= table_q[bus.in_vec];
            end
        end
    end

    assign bus.f         = f_q;
    assign bus.out_valid = out_valid_q;
`else
    // Zero-latency lookup, forced low while reset is asserted.
    assign bus.f         = rst ? 1'b0 : table_q[bus.in_vec];
    assign bus.out_valid = bus.in_valid & ~rst;
`endif
endmodule

// File: tb/tb_lut_func_eval.sv
// Self-checking bench for lut_func_eval (N=3) with a lookup scoreboard.
// Latency: follows LUT_FUNC_EVAL_REG_OUT_EN for lookup expectations.
// Backpressure: n/a.
module tb_lut_func_eval;
    localparam int N   = 3;
    localparam int TBL = 1 << N;
`ifdef LUT_FUNC_EVAL_REG_OUT_EN
    localparam bit REG = 1'b1;
`else
    localparam bit REG = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    int   compared   = 0;
    int   mismatched = 0;
    logic exp_q[$];
    logic exp_f;
    logic [TBL-1:0] model_tbl;

    lut_func_eval_if #(.N(N)) bus ();
    lut_func_eval #(.N(N)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached, expected normal completion");
        $fatal(1);
    end

    // Scoreboard: every valid output must match the oldest pending request.
    always @(negedge clk) begin
        if (bus.out_valid === 1'b1) begin
            compared++;
            if (exp_q.size() == 0) begin
                mismatched++;
                $display("FAIL lookup_spurious: out_valid=1 with no pending request");
            end else begin
                exp_f = exp_q.pop_front();
                if (bus.f !== exp_f) begin
                    mismatched++;
                    $display("FAIL lookup_f: got %b expected %b", bus.f, exp_f);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_bits(input logic [7:0] bits, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            bus.cfg_valid = 1'b1;
            bus.cfg_bit   = bits[i];
            model_tbl     = {model_tbl[TBL-2:0], bits[i]};
            step();
        end
        bus.cfg_valid = 1'b0;
    endtask

    task automatic lookup(input logic [N-1:0] v);
        bus.in_valid = 1'b1;
        bus.in_vec   = v;
        exp_q.push_back(model_tbl[v]);
    endtask

    task automatic check_drained(input string name);
        step();
        step();
        compared++;
        if (exp_q.size() != 0) begin
            mismatched++;
            $display("FAIL %s_drain: pending=%0d expected 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic run_sweep(input logic [N:0] exp_cnt, input bit with_cfg,
                             input logic cfg_b, input bit disturb, input string name);
        bus.sweep_start = 1'b1;
        if (with_cfg) begin
            bus.cfg_valid = 1'b1;
            bus.cfg_bit   = cfg_b;
            model_tbl     = {model_tbl[TBL-2:0], cfg_b};
        end
        step();
        bus.sweep_start = 1'b0;
        bus.cfg_valid   = 1'b0;
        for (int k = 1; k <= TBL + 3; k++) begin
            if (k > 1) step();
            if (disturb) begin
                if (k == 3) begin
                    bus.cfg_valid   = 1'b1;
                    bus.cfg_bit     = 1'b1;
                    bus.sweep_start = 1'b1;
                end
                if (k == 4) begin
                    bus.cfg_valid   = 1'b0;
                    bus.sweep_start = 1'b0;
                end
                if (k == 5) lookup(3'b000);
                if (k == 6) bus.in_valid = 1'b0;
            end
            @(negedge clk);
            compared++;
            if (bus.sweep_busy !== (k <= TBL)) begin
                mismatched++;
                $display("FAIL %s_busy c%0d: got %b expected %b", name, k, bus.sweep_busy, (k <= TBL));
            end
            compared++;
            if (bus.sweep_done !== (k == TBL + 1)) begin
                mismatched++;
                $display("FAIL %s_done c%0d: got %b expected %b", name, k, bus.sweep_done, (k == TBL + 1));
            end
            if (k >= TBL + 1) begin
                compared++;
                if (bus.ones_count !== exp_cnt) begin
                    mismatched++;
                    $display("FAIL %s_ones c%0d: got %0d expected %0d", name, k, bus.ones_count, exp_cnt);
                end
            end
        end
    endtask

    task automatic test_reset();
        rst             = 1'b1;
        bus.cfg_valid   = 1'b0;
        bus.cfg_bit     = 1'b0;
        bus.in_valid    = 1'b1;
        bus.in_vec      = 3'b111;
        bus.sweep_start = 1'b0;
        model_tbl       = '0;
        @(negedge clk);
        compared++;
        if (bus.f !== 1'b0) begin mismatched++; $display("FAIL reset_f: got %b expected 0", bus.f); end
        compared++;
        if (bus.out_valid !== 1'b0) begin mismatched++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid); end
        compared++;
        if (bus.sweep_busy !== 1'b0) begin mismatched++; $display("FAIL reset_busy: got %b expected 0", bus.sweep_busy); end
        compared++;
        if (bus.sweep_done !== 1'b0) begin mismatched++; $display("FAIL reset_done: got %b expected 0", bus.sweep_done); end
        compared++;
        if (bus.ones_count !== '0) begin mismatched++; $display("FAIL reset_ones: got %0d expected 0", bus.ones_count); end
        step();
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        run_sweep(4'd0, 1'b0, 1'b0, 1'b0, "sweep_after_reset");
    endtask

    task automatic test_lookup();
        step();
        load_bits(8'b10110010, 8);
        lookup(3'b101);
        @(negedge clk);
        compared++;
        if (bus.out_valid !== !REG) begin
            mismatched++;
            $display("FAIL lookup_latency: out_valid got %b expected %b", bus.out_valid, !REG);
        end
        step();
        lookup(3'b011);
        step();
        lookup(3'b100);
        step();
        bus.in_valid = 1'b0;
        @(negedge clk);
        if (REG) @(negedge clk);
        compared++;
        if (bus.out_valid !== 1'b0) begin
            mismatched++;
            $display("FAIL lookup_idle_valid: got %b expected 0", bus.out_valid);
        end
        compared++;
        if (bus.f !== model_tbl[4]) begin
            mismatched++;
            $display("FAIL lookup_idle_f: got %b expected %b", bus.f, model_tbl[4]);
        end
        check_drained("lookup");
    endtask

    task automatic test_sweep();
        run_sweep(4'd4, 1'b0, 1'b0, 1'b0, "sweep");
        for (int i = 0; i < 10; i++) step();
        compared++;
        if (bus.ones_count !== 4'd4) begin
            mismatched++;
            $display("FAIL sweep_hold: got %0d expected 4", bus.ones_count);
        end
    endtask

    task automatic test_sweep_disturb();
        step();
        run_sweep(4'd4, 1'b0, 1'b0, 1'b1, "disturb");
        check_drained("disturb");
    endtask

    task automatic test_reset_mid_sweep();
        bus.sweep_start = 1'b1;
        step();
        bus.sweep_start = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            if (k > 1) step();
            if (k == 4) rst = 1'b1;
            if (k == 5) begin
                rst       = 1'b0;
                model_tbl = '0;
            end
            @(negedge clk);
            compared++;
            if (bus.sweep_busy !== (k <= 4)) begin
                mismatched++;
                $display("FAIL midrst_busy c%0d: got %b expected %b", k, bus.sweep_busy, (k <= 4));
            end
            if (k >= 5) begin
                compared++;
                if (bus.ones_count !== '0) begin
                    mismatched++;
                    $display("FAIL midrst_ones c%0d: got %0d expected 0", k, bus.ones_count);
                end
                compared++;
                if (bus.sweep_done !== 1'b0) begin
                    mismatched++;
                    $display("FAIL midrst_done c%0d: got %b expected 0", k, bus.sweep_done);
                end
            end
        end
        step();
        lookup(3'b111);
        step();
        bus.in_valid = 1'b0;
        check_drained("midrst");
    endtask

    task automatic test_full_table();
        load_bits(8'hFF, 8);
        run_sweep(4'd8, 1'b0, 1'b0, 1'b0, "full");
        step();
        load_bits(8'h7F, 7);
        run_sweep(4'd7, 1'b1, 1'b0, 1'b0, "samecycle");
        step();
        lookup(3'b000);
        step();
        lookup(3'b001);
        step();
        bus.in_valid = 1'b0;
        check_drained("samecycle");
    endtask

    initial begin
        test_reset();
        test_lookup();
        test_sweep();
        test_sweep_disturb();
        test_reset_mid_sweep();
        test_full_table();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/lut_func_eval.md
# lut_func_eval

Programmable N-input Boolean function unit. Replaces fixed hand-minimised sum-of-products gates with a serially loaded truth table. Provides a lookup path for evaluation and a sweep engine that steps through every minterm and counts the ON-set, which is used to check a loaded function against its expected minterm count. It sits beside the existing combinational exercise blocks as their general-purpose, testable successor.

## Interface

Parameters:
- N, 3, number of function inputs; truth table is 2^N bits; legal range 1–8

Ports:
- clk  in  1  single clock; all state changes on its rising edge
- rst  in  1  synchronous, active-high reset
- cfg_valid  in  1  shift one truth-table bit in this cycle
- cfg_bit  in  1  truth-table bit to shift in
- in_valid  in  1  lookup request
- in_vec  in  N  minterm index to evaluate
- f  out  1  function value table[in_vec]
- out_valid  out  1  f corresponds to an accepted lookup
- sweep_start  in  1  start a minterm sweep
- sweep_busy  out  1  sweep in progress
- sweep_done  out  1  one-cycle pulse when ones_count is updated
- ones_count  out  N+1  number of 1s in the table from the last completed sweep

## Operation

- Table register `table[2^N-1:0]` is reset to all zeros.
- Load: when cfg_valid is high and the state is not SWEEP, the shift is `table <= {table[2^N-2:0], cfg_bit}`. After 2^N shifts, the first bit loaded sits at index 2^N-1.
- While in SWEEP, cfg_valid is ignored and the table is frozen.
- Lookup: f = table[in_vec]. The lookup reads the table value from before any shift in the same cycle. Lookups are serviced in every state, including SWEEP.
- FSM states:
  - IDLE: sweep_start → SWEEP; clear the accumulator and the index.
  - SWEEP: each cycle, acc += table[idx] and idx++. When idx = 2^N-1, ones_count <= acc + table[idx] and the FSM moves to DONE.
  - DONE: lasts one cycle, then returns to IDLE. sweep_start in DONE behaves as in IDLE.
- sweep_start while in SWEEP is ignored.
- If cfg_valid and sweep_start are high in the same cycle (IDLE or DONE), the shift is applied and the sweep sees the updated table.
- Width rules:
  - idx is N bits and wraps only at sweep end.
  - acc and ones_count are N+1 bits, so the value 2^N is representable.
- ones_count holds its value until the next sweep completes.
- rst takes effect at the next edge, including mid-sweep:
  - state → IDLE
  - table, acc, idx → 0
  - all outputs → 0

## Timing

- Reset values: f=0, out_valid=0, sweep_busy=0, sweep_done=0, ones_count=0.
- Sweep with sweep_start sampled at edge t:
  - sweep_busy is high for cycles t+1 … t+2^N.
  - sweep_done pulses in cycle t+2^N+1.
  - ones_count is valid from cycle t+2^N+1.
- sweep_busy = (state==SWEEP). sweep_done = (state==DONE).
- Lookup latency depends on the configuration macro (see Configuration).

## Configuration

- Macro LUT_FUNC_EVAL_REG_OUT_EN:
  - Defined:
    - f and out_valid are registered: in_valid/in_vec at edge t produce f and out_valid=1 in cycle t+1.
    - out_valid is 0 in any cycle following a cycle with no request.
    - f holds its last value when out_valid is 0.
  - Undefined:
    - f = table[in_vec] combinationally, with zero latency.
    - out_valid = in_valid.
    - Both are 0 during rst.

## Test plan

- Reset, then sweep immediately (N=3) → all outputs 0 during reset; sweep_busy for 8 cycles, sweep_done in cycle 9, ones_count=0.
- Load the bits 1,0,1,1,0,0,1,0 in that order (table=8'b10110010), then look up 3'b101, 3'b011, 3'b100 → f=1, 0, 1, at the latency set by the macro.
- Sweep on the table 8'b10110010 → sweep_done at t+9, ones_count=4; ones_count still 4 ten cycles later.
- Mid-sweep disturbances:
  - Assert cfg_valid with cfg_bit=1 mid-sweep, and re-assert sweep_start mid-sweep → both ignored; ones_count=4; lookup 3'b000 → f=0; exactly one sweep_done pulse.
  - Assert rst at sweep cycle 4 → next cycle: sweep_busy=0, ones_count=0; lookup 3'b111 → f=0.
- Load eight 1s, then sweep → ones_count=4'b1000 (no overflow). Same-cycle cfg_valid with sweep_start, with the final 0 as the last shifted bit → ones_count=7.
